tone_prescaler: RTL and testbench

//  Downstream of the tone decoder. Consumes its 10-bit prescale value (50MHz/256/f) and divides clk by it.

---
 rtl/sound_pkg.sv | 23 ++
 rtl/tick_divider.sv | 62 ++++++
 rtl/tone_prescaler.sv | 59 +++++
 tb/tb_tone_prescaler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared widths, types and divisor helper for the sound unit.
package sound_pkg;

  localparam int unsigned PRESCALE_W = 10;
  localparam int unsigned PHASE_W    = 8;
  localparam int unsigned MIN_DIV    = 2;

  typedef logic [PRESCALE_W-1:0] prescale_t;
  typedef logic [PHASE_W-1:0]    phase_t;

  // Octave-shifted divisor; zero means silence, tiny non-zero values are clamped up.
  function automatic prescale_t eff_divisor(prescale_t value, logic [1:0] octave);
    prescale_t raw;
    raw = value >> octave;
    if (raw == '0) begin
      return '0;
    end else if (raw < prescale_t'(MIN_DIV)) begin
      return prescale_t'(MIN_DIV);
    end
    return raw;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock divider: holds the effective divisor, counts clocks and issues the sample tick.
module tick_divider
  import sound_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            octave,
  input  logic                  phase_max,
  output logic                  tick_c,
  output logic                  eff_nz_c,
  output logic                  sample_tick
);

  prescale_t div_cnt, div_cnt_d;
  prescale_t eff_div, eff_div_d;
  prescale_t eff_next;
  logic      active;
  logic      load_c;

  // A divisor change is only picked up at restart, at wrap, or while silent.
  always_comb begin
    eff_next = eff_divisor(prescale, octave);
    tick_c   = enable && (eff_div != '0) && (div_cnt == eff_div - prescale_t'(1));
    load_c   = enable && (!active || (tick_c && phase_max) || (eff_div == '0));
  end

  always_comb begin
    eff_div_d = eff_div;
    div_cnt_d = div_cnt;
    if (!enable) begin
      eff_div_d = '0;
      div_cnt_d = '0;
    end else begin
      if (load_c) begin
        eff_div_d = eff_next;
      end
      if (!active || (eff_div == '0) || tick_c) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt + prescale_t'(1);
      end
    end
    eff_nz_c = (eff_div_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      div_cnt     <= '0;
      eff_div     <= '0;
      active      <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_d;
      eff_div     <= eff_div_d;
      active      <= enable;
      sample_tick <= tick_c;
    end
  end

endmodule

// File: rtl/tone_prescaler.sv
// Tone prescaler: divided sample tick, wave-phase address, period strobe and square wave.
module tone_prescaler
  import sound_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  mute,
  input  logic [PRESCALE_W-1:0] preScaleValue,
  input  logic [1:0]            octave,
  output logic                  sample_tick,
  output logic [PHASE_W-1:0]    phase,
  output logic                  period_done,
  output logic                  square_out
);

  logic   tick_c;
  logic   eff_nz_c;
  logic   phase_max;
  logic   wrap_c;
  phase_t phase_d;

  tick_divider u_tick_divider (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .prescale    (preScaleValue),
    .octave      (octave),
    .phase_max   (phase_max),
    .tick_c      (tick_c),
    .eff_nz_c    (eff_nz_c),
    .sample_tick (sample_tick)
  );

  always_comb begin
    phase_max = &phase;
    wrap_c    = tick_c && phase_max;
    phase_d   = phase;
    if (!enable) begin
      phase_d = '0;
    end else if (tick_c) begin
      phase_d = phase + phase_t'(1);
    end
  end

  // Square wave tracks the MSB of the phase being registered alongside it.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      phase       <= '0;
      period_done <= 1'b0;
      square_out  <= 1'b0;
    end else begin
      phase       <= phase_d;
      period_done <= wrap_c;
      square_out  <= phase_d[PHASE_W-1] & enable & ~mute & eff_nz_c;
    end
  end

endmodule

// File: tb/tb_tone_prescaler.sv
// Randomised and directed bench for tone_prescaler against a countdown-based reference model.
module tb_tone_prescaler;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       mute;
  logic [9:0] psv;
  logic [1:0] octave;
  logic       sample_tick;
  logic [7:0] phase;
  logic       period_done;
  logic       square_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining clocks until the next tick, plus the tone state.
  int m_eff, m_rem, m_phase;
  bit m_tick, m_done, m_sq, m_act;

  tone_prescaler dut (
    .clk           (clk),
    .resetN        (resetN),
    .enable        (enable),
    .mute          (mute),
    .preScaleValue (psv),
    .octave        (octave),
    .sample_tick   (sample_tick),
    .phase         (phase),
    .period_done   (period_done),
    .square_out    (square_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int want_div(input int value, input int oct);
    int raw;
    raw = value / (1 << oct);
    if (raw == 0) return 0;
    if (raw < 2) return 2;
    return raw;
  endfunction

  task automatic model_edge();
    int nxt;
    nxt = want_div(int'(psv), int'(octave));
    if (!resetN || !enable) begin
      m_eff = 0; m_rem = 0; m_phase = 0;
      m_tick = 0; m_done = 0; m_sq = 0; m_act = 0;
    end else begin
      m_tick = m_act && (m_eff != 0) && (m_rem == 1);
      m_done = m_tick && (m_phase == 255);
      if (!m_act || m_eff == 0) begin
        m_eff = nxt;
        m_rem = nxt;
      end else if (m_tick) begin
        m_phase = (m_phase + 1) % 256;
        if (m_done) m_eff = nxt;
        m_rem = m_eff;
      end else begin
        m_rem = m_rem - 1;
      end
      m_sq  = (m_phase >= 128) && !mute && (m_eff != 0);
      m_act = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sample_tick", int'(sample_tick), int'(m_tick));
    chk("period_done", int'(period_done), int'(m_done));
    chk("square_out", int'(square_out), int'(m_sq));
    chk("phase", int'(phase), m_phase);
  endtask

  // Steps until a tick is seen; n is the number of edges taken.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < budget);
    if (!sample_tick) chk("tick_timeout", int'(sample_tick), 1);
  endtask

  task automatic wait_phase(input int target, input int budget);
    int k;
    k = 0;
    while (int'(phase) != target && k < budget) begin
      step();
      k++;
    end
    if (int'(phase) != target) chk("phase_timeout", int'(phase), target);
  endtask

  task automatic restart(input int value, input int oct);
    enable = 1'b0;
    step();
    psv    = 10'(value);
    octave = 2'(oct);
    enable = 1'b1;
  endtask

  initial begin
    int n, k;
    resetN = 1'b0; enable = 1'b0; mute = 1'b0; psv = '0; octave = '0;
    repeat (3) step();
    chk("rst_phase", int'(phase), 0);
    resetN = 1'b1;

    // 440 Hz tone spacing, octave shifts and clamping
    restart(12'h1BB, 0);
    wait_tick(1000, n); wait_tick(1000, n);
    chk("gap_443", n, 443);
    restart(12'h1BB, 1);
    wait_tick(500, n); wait_tick(500, n);
    chk("gap_oct1", n, 221);
    restart(12'h1BB, 3);
    wait_tick(200, n); wait_tick(200, n);
    chk("gap_oct3", n, 55);
    restart(1, 0);
    wait_tick(10, n); wait_tick(10, n);
    chk("gap_clamp", n, 2);

    // Mid-period divisor change waits for the wrap
    restart(3, 0);
    wait_phase(100, 400);
    psv = 10'd5;
    wait_tick(10, n); wait_tick(10, n);
    chk("pre_wrap_gap", n, 3);
    k = 0;
    while (!period_done && k < 1000) begin step(); k++; end
    chk("wrap_seen", int'(period_done), 1);
    wait_tick(10, n);
    chk("post_wrap_gap", n, 5);

    // Silence, then first tick after the load edge
    restart(0, 0);
    repeat (40) step();
    chk("silent_phase", int'(phase), 0);
    psv = 10'h18B;
    wait_tick(500, n);
    chk("first_tick", n - 1, 395);

    // Mute and idle
    restart(2, 0);
    wait_phase(130, 700);
    mute = 1'b1;
    step();
    chk("mute_sq", int'(square_out), 0);
    repeat (10) step();
    mute = 1'b0;
    enable = 1'b0;
    step();
    chk("idle_phase", int'(phase), 0);
    repeat (10) step();

    // Reset mid-tone, then restart from phase 0
    restart(2, 0);
    wait_phase(200, 700);
    resetN = 1'b0;
    step();
    chk("rst_tick", int'(sample_tick), 0);
    chk("rst_phase_mid", int'(phase), 0);
    resetN = 1'b1;
    wait_tick(10, n);
    chk("rst_first_tick", n - 1, 2);

    // Random segments
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        psv    = 10'($urandom_range(0, 1023));
        octave = 2'd3;
      end else begin
        psv    = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 6));
        octave = 2'($urandom_range(0, 3));
      end
      enable = ($urandom_range(0, 9) != 0);
      mute   = ($urandom_range(0, 4) == 0);
      resetN = ($urandom_range(0, 14) != 0);
      step();
      resetN = 1'b1;
      k = $urandom_range(50, 800);
      for (int c = 0; c < k; c++) begin
        if ($urandom_range(0, 199) == 0) mute = ~mute;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
